// File: rtl/mem_stage_hs.sv
// rtl/mem_stage_hs.sv - pipeline memory stage with request/acknowledge bus handshake
// Generates byte strobes, aligns and extends loads, and reports misalignment and bus faults.
module mem_stage_hs #(
  parameter int XLEN    = 32,
  parameter int WB_W    = 22,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              exception_in,
  input  logic [3:0]        ecause_in,
  input  logic              load_in,
  input  logic              store_in,
  input  logic [1:0]        size_in,
  input  logic              signed_in,
  input  logic [XLEN-1:0]   addr_in,
  input  logic [XLEN-1:0]   store_data_in,
  input  logic [XLEN-1:0]   pc_in,
  input  logic [XLEN-1:0]   alu_data_in,
  input  logic [WB_W-1:0]   wb_ctrl_in,
  input  logic              stall_in,
  input  logic              invalidate,
  output logic              busy,
  output logic              bus_req,
  output logic              bus_we,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [XLEN/8-1:0] bus_strb,
  input  logic              bus_ack,
  input  logic              bus_err,
  input  logic [XLEN-1:0]   bus_rdata,
  output logic              valid_out,
  output logic              exception_out,
  output logic [3:0]        ecause_out,
  output logic [XLEN-1:0]   pc_out,
  output logic [XLEN-1:0]   alu_data_out,
  output logic [XLEN-1:0]   load_data_out,
  output logic [WB_W-1:0]   wb_ctrl_out
);

  localparam int SW = XLEN / 8;
  localparam int LW = $clog2(SW);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;
  state_t state, state_next;

  logic [LW-1:0]   lane;
  logic            is_mem, aligned, start, misal;
  logic            to_hit, ack_eff, err_eff, fault, v_new;
  logic [31:0]     to_cnt;
  logic            kill_q, hold_err;
  logic            acc_load_q, acc_signed_q;
  logic [1:0]      acc_size_q;
  logic [LW-1:0]   acc_lane_q;
  logic [XLEN-1:0] hold_data, load_aligned;
  logic [SW-1:0]   strb_base;

  function automatic logic [XLEN-1:0] align_load(input logic [XLEN-1:0] rdata,
                                                 input logic [LW-1:0] ln,
                                                 input logic [1:0] sz,
                                                 input logic sg);
    logic [XLEN-1:0] sh;
    int msb;
    sh = rdata >> {ln, 3'b000};
    case (sz)
      2'd0:    msb = 7;
      2'd1:    msb = 15;
      2'd2:    msb = 31;
      default: msb = XLEN - 1;
    endcase
    for (int i = 0; i < XLEN; i++)
      if (i > msb) sh[i] = sg & sh[msb];
    return sh;
  endfunction

  assign lane   = addr_in[LW-1:0];
  assign is_mem = load_in | store_in;

  always_comb begin
    aligned = 1'b1;
    case (size_in)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~addr_in[0];
      2'd2:    aligned = (addr_in[1:0] == 2'b00);
      default: aligned = (XLEN == 64) && (addr_in[2:0] == 3'b000);
    endcase
  end

  always_comb begin
    strb_base = SW'(1);
    case (size_in)
      2'd0:    strb_base = SW'(1);
      2'd1:    strb_base = SW'(3);
      2'd2:    strb_base = SW'(15);
      default: strb_base = SW'(255);
    endcase
  end

  assign start = (state == IDLE) && valid_in && !exception_in && is_mem && aligned
                 && !invalidate && !stall_in;
  assign misal = !exception_in && is_mem && !aligned;

  // A timeout behaves as an errored ack so the faulting instruction retires normally.
  assign to_hit  = (TIMEOUT != 0) && (state == ACCESS) && !bus_ack && (to_cnt == TO_LAST);
  assign ack_eff = (state == ACCESS) && (bus_ack || to_hit);
  assign err_eff = bus_ack ? bus_err : 1'b1;
  assign fault   = (state == HOLD) ? hold_err : ((state == ACCESS) && err_eff);
  assign v_new   = valid_in && !invalidate && !kill_q;

  assign load_aligned = align_load(bus_rdata, acc_lane_q, acc_size_q, acc_signed_q);

  // HOLD releases upstream in the cycle the held result retires, like the ack cycle of ACCESS.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        busy = start;
        if (start) state_next = ACCESS;
      end
      ACCESS: begin
        busy = !ack_eff;
        if (ack_eff) state_next = stall_in ? HOLD : IDLE;
      end
      HOLD: begin
        busy = stall_in;
        if (!stall_in) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      bus_strb     <= '0;
      acc_load_q   <= 1'b0;
      acc_signed_q <= 1'b0;
      acc_size_q   <= 2'd0;
      acc_lane_q   <= '0;
    end else if (start) begin
      bus_req      <= 1'b1;
      bus_we       <= store_in;
      bus_addr     <= {addr_in[XLEN-1:LW], {LW{1'b0}}};
      bus_wdata    <= store_data_in << {lane, 3'b000};
      bus_strb     <= strb_base << lane;
      acc_load_q   <= load_in;
      acc_signed_q <= signed_in;
      acc_size_q   <= size_in;
      acc_lane_q   <= lane;
    end else if (ack_eff) begin
      bus_req <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt    <= '0;
      kill_q    <= 1'b0;
      hold_data <= '0;
      hold_err  <= 1'b0;
    end else begin
      to_cnt <= (state == ACCESS && !ack_eff) ? to_cnt + 32'd1 : 32'd0;
      kill_q <= (state_next != IDLE) && (kill_q || (state != IDLE && invalidate));
      if (ack_eff && stall_in) begin
        hold_data <= load_aligned;
        hold_err  <= err_eff;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out     <= 1'b0;
      exception_out <= 1'b0;
      ecause_out    <= 4'd0;
      pc_out        <= '0;
      alu_data_out  <= '0;
      load_data_out <= '0;
      wb_ctrl_out   <= '0;
    end else if (stall_in) begin
      valid_out     <= valid_out && !invalidate && !kill_q;
      exception_out <= exception_out && !invalidate && !kill_q;
    end else if (busy) begin
      valid_out     <= 1'b0;
      exception_out <= 1'b0;
    end else begin
      valid_out     <= v_new;
      exception_out <= v_new && (exception_in || misal || fault);
      if (exception_in)  ecause_out <= ecause_in;
      else if (misal)    ecause_out <= load_in ? 4'd4 : 4'd6;
      else if (fault)    ecause_out <= acc_load_q ? 4'd5 : 4'd7;
      else               ecause_out <= 4'd0;
      pc_out        <= pc_in;
      alu_data_out  <= alu_data_in;
      wb_ctrl_out   <= wb_ctrl_in;
      load_data_out <= (state == HOLD) ? hold_data : load_aligned;
    end
  end

endmodule

// File: tb/tb_mem_stage_hs.sv
// tb/tb_mem_stage_hs.sv - self-checking bench for mem_stage_hs
// Drives instructions, plays a bus slave, and compares against an arithmetic reference model.
module tb_mem_stage_hs;

  localparam int XLEN = 32;
  localparam int WB_W = 22;
  localparam int TO   = 4;

  logic            clk, rst_n;
  logic            valid_in, exception_in, load_in, store_in, signed_in;
  logic [3:0]      ecause_in;
  logic [1:0]      size_in;
  logic [31:0]     addr_in, store_data_in, pc_in, alu_data_in;
  logic [WB_W-1:0] wb_ctrl_in;
  logic            stall_in, invalidate;
  logic            busy, bus_req, bus_we, bus_ack, bus_err;
  logic [31:0]     bus_addr, bus_wdata, bus_rdata;
  logic [3:0]      bus_strb;
  logic            valid_out, exception_out;
  logic [3:0]      ecause_out;
  logic [31:0]     pc_out, alu_data_out, load_data_out;
  logic [WB_W-1:0] wb_ctrl_out;

  mem_stage_hs #(.XLEN(XLEN), .WB_W(WB_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .exception_in(exception_in),
    .ecause_in(ecause_in), .load_in(load_in), .store_in(store_in), .size_in(size_in),
    .signed_in(signed_in), .addr_in(addr_in), .store_data_in(store_data_in),
    .pc_in(pc_in), .alu_data_in(alu_data_in), .wb_ctrl_in(wb_ctrl_in),
    .stall_in(stall_in), .invalidate(invalidate), .busy(busy), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_strb(bus_strb),
    .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata), .valid_out(valid_out),
    .exception_out(exception_out), .ecause_out(ecause_out), .pc_out(pc_out),
    .alu_data_out(alu_data_out), .load_data_out(load_data_out), .wb_ctrl_out(wb_ctrl_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic            o_busy0, o_we, o_stable, o_valid, o_exc;
  int              o_busy_cnt, o_req_cnt, o_hold_bad;
  logic [31:0]     o_addr, o_wdata, o_ld, o_pc, o_alu, e_pc, e_alu;
  logic [3:0]      o_strb, o_cause;
  logic [WB_W-1:0] o_wb, e_wb;

  function automatic logic f_aligned(input logic [1:0] sz, input logic [31:0] a);
    return (sz != 2'd3) && ((a % (32'd1 << sz)) == 32'd0);
  endfunction

  function automatic logic [3:0] f_strb(input logic [1:0] sz, input logic [31:0] a);
    int v;
    v = ((1 << (1 << sz)) - 1) << (a % 4);
    return 4'(v);
  endfunction

  function automatic logic [31:0] f_wdata(input logic [31:0] d, input logic [31:0] a);
    return d << (8 * (a % 4));
  endfunction

  function automatic logic [31:0] f_load(input logic [31:0] rd, input logic [31:0] a,
                                         input logic [1:0] sz, input logic sg);
    logic [63:0] sh, mask;
    int nbits;
    sh = {32'd0, rd >> (8 * (a % 4))};
    nbits = 8 << sz;
    if (nbits >= 32) return sh[31:0];
    mask = (64'd1 << nbits) - 64'd1;
    sh = sh & mask;
    if (sg && sh[nbits-1]) sh = sh | ~mask;
    return sh[31:0];
  endfunction

  // lat: request cycle carrying the ack (0 = never); stall_len: stall cycles from the ack cycle.
  task automatic run_access(input logic ld, input logic st, input logic [1:0] sz, input logic sg,
                            input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [31:0] rdata, input int lat, input logic err,
                            input int stall_len, input int inval_at, input logic exc,
                            input logic [3:0] ec);
    valid_in = 1'b1; exception_in = exc; ecause_in = ec; load_in = ld; store_in = st;
    size_in = sz; signed_in = sg; addr_in = addr; store_data_in = sdata;
    pc_in = $urandom; alu_data_in = $urandom; wb_ctrl_in = WB_W'($urandom);
    e_pc = pc_in; e_alu = alu_data_in; e_wb = wb_ctrl_in;
    stall_in = 1'b0; invalidate = 1'b0; bus_ack = 1'b0; bus_err = 1'b0;
    #1;
    o_busy0 = busy;
    o_busy_cnt = int'(busy);
    @(posedge clk); #1;
    o_req_cnt = 0; o_stable = 1'b1; o_hold_bad = 0;
    for (int c = 1; c <= 8; c++) begin
      if (!bus_req) break;
      o_req_cnt++;
      if (c == 1) begin
        o_we = bus_we; o_addr = bus_addr; o_wdata = bus_wdata; o_strb = bus_strb;
      end else if (bus_we !== o_we || bus_addr !== o_addr || bus_wdata !== o_wdata ||
                   bus_strb !== o_strb) begin
        o_stable = 1'b0;
      end
      invalidate = (c == inval_at);
      if (c == lat) begin
        bus_ack = 1'b1; bus_err = err; bus_rdata = rdata; stall_in = (stall_len > 0);
      end
      #1;
      o_busy_cnt += int'(busy);
      @(posedge clk); #1;
      bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = $urandom; invalidate = 1'b0;
    end
    for (int s = 1; s < stall_len; s++) begin
      #1;
      if (busy !== 1'b1 || valid_out !== 1'b0) o_hold_bad++;
      @(posedge clk); #1;
    end
    if (stall_len > 0) begin
      stall_in = 1'b0;
      @(posedge clk); #1;
    end
    o_valid = valid_out; o_exc = exception_out; o_cause = ecause_out; o_ld = load_data_out;
    o_pc = pc_out; o_alu = alu_data_out; o_wb = wb_ctrl_out;
    valid_in = 1'b0; load_in = 1'b0; store_in = 1'b0; exception_in = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid_in = 0; exception_in = 0; ecause_in = 0; load_in = 0; store_in = 0; size_in = 0;
    signed_in = 0; addr_in = 0; store_data_in = 0; pc_in = 0; alu_data_in = 0; wb_ctrl_in = 0;
    stall_in = 0; invalidate = 0; bus_ack = 0; bus_err = 0; bus_rdata = 0;
    #22;
    n_chk++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_bus_req: got %b want 0", bus_req); end
    n_chk++; if ({bus_we, bus_addr, bus_wdata, bus_strb} !== '0) begin n_fail++; $display("FAIL reset_bus_fields: got %b %h %h %h want all 0", bus_we, bus_addr, bus_wdata, bus_strb); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if ({valid_out, exception_out, ecause_out} !== 6'd0) begin n_fail++; $display("FAIL reset_status: got %b %b %h want 0 0 0", valid_out, exception_out, ecause_out); end
    n_chk++; if ({pc_out, alu_data_out, load_data_out, wb_ctrl_out} !== '0) begin n_fail++; $display("FAIL reset_data: got %h %h %h %h want 0", pc_out, alu_data_out, load_data_out, wb_ctrl_out); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word_load();
    run_access(1, 0, 2'd2, 0, 32'h1004, 32'h0, 32'hDEADBEEF, 4, 0, 0, 0, 0, 4'h0);
    n_chk++; if (o_ld !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_load_data: got %h want deadbeef", o_ld); end
    n_chk++; if (o_busy_cnt !== 4) begin n_fail++; $display("FAIL word_busy_cycles: got %0d want 4", o_busy_cnt); end
    n_chk++; if (o_req_cnt !== 4) begin n_fail++; $display("FAIL word_req_cycles: got %0d want 4", o_req_cnt); end
    n_chk++; if ({o_valid, o_exc} !== 2'b10) begin n_fail++; $display("FAIL word_valid_exc: got %b%b want 10", o_valid, o_exc); end
    n_chk++; if ({o_we, o_addr, o_strb, o_stable} !== {1'b0, 32'h1004, 4'hF, 1'b1}) begin n_fail++; $display("FAIL word_bus: got we=%b addr=%h strb=%h stable=%b want 0 1004 f 1", o_we, o_addr, o_strb, o_stable); end
  endtask

  task automatic test_byte_load();
    run_access(1, 0, 2'd0, 1, 32'h1003, 32'h0, 32'h80000000, 1, 0, 0, 0, 0, 4'h0);
    n_chk++; if (o_strb !== 4'b1000) begin n_fail++; $display("FAIL byte_strb: got %b want 1000", o_strb); end
    n_chk++; if (o_ld !== 32'hFFFFFF80) begin n_fail++; $display("FAIL byte_signed: got %h want ffffff80", o_ld); end
    n_chk++; if (o_addr !== 32'h1000) begin n_fail++; $display("FAIL byte_addr: got %h want 1000", o_addr); end
    n_chk++; if (o_busy_cnt !== 1) begin n_fail++; $display("FAIL byte_busy_min: got %0d want 1", o_busy_cnt); end
    run_access(1, 0, 2'd0, 0, 32'h1003, 32'h0, 32'h80000000, 1, 0, 0, 0, 0, 4'h0);
    n_chk++; if (o_ld !== 32'h00000080) begin n_fail++; $display("FAIL byte_unsigned: got %h want 00000080", o_ld); end
  endtask

  task automatic test_half_store();
    run_access(0, 1, 2'd1, 0, 32'h2002, 32'h1234, 32'h0, 2, 0, 0, 0, 0, 4'h0);
    n_chk++; if (o_wdata !== 32'h12340000) begin n_fail++; $display("FAIL half_wdata: got %h want 12340000", o_wdata); end
    n_chk++; if (o_strb !== 4'b1100) begin n_fail++; $display("FAIL half_strb: got %b want 1100", o_strb); end
    n_chk++; if (o_we !== 1'b1) begin n_fail++; $display("FAIL half_we: got %b want 1", o_we); end
    n_chk++; if ({o_valid, o_exc} !== 2'b10) begin n_fail++; $display("FAIL half_valid_exc: got %b%b want 10", o_valid, o_exc); end
  endtask

  task automatic test_misaligned();
    run_access(1, 0, 2'd2, 0, 32'h1002, 32'h0, 32'h0, 1, 0, 0, 0, 0, 4'h0);
    n_chk++; if (o_req_cnt !== 0) begin n_fail++; $display("FAIL mis_load_req: got %0d want 0", o_req_cnt); end
    n_chk++; if (o_busy0 !== 1'b0) begin n_fail++; $display("FAIL mis_load_busy: got %b want 0", o_busy0); end
    n_chk++; if ({o_exc, o_cause} !== {1'b1, 4'd4}) begin n_fail++; $display("FAIL mis_load_cause: got %b/%0d want 1/4", o_exc, o_cause); end
    run_access(0, 1, 2'd1, 0, 32'h2001, 32'h55, 32'h0, 1, 0, 0, 0, 0, 4'h0);
    n_chk++; if ({o_req_cnt == 0, o_exc, o_cause} !== {1'b1, 1'b1, 4'd6}) begin n_fail++; $display("FAIL mis_store: got req=%0d exc=%b cause=%0d want 0/1/6", o_req_cnt, o_exc, o_cause); end
  endtask

  task automatic test_faults();
    run_access(1, 0, 2'd2, 0, 32'h3000, 32'h0, 32'h0, 0, 0, 0, 0, 0, 4'h0);
    n_chk++; if (o_req_cnt !== TO) begin n_fail++; $display("FAIL timeout_req_cycles: got %0d want %0d", o_req_cnt, TO); end
    n_chk++; if ({o_valid, o_exc, o_cause} !== {1'b1, 1'b1, 4'd5}) begin n_fail++; $display("FAIL timeout_cause: got %b%b/%0d want 11/5", o_valid, o_exc, o_cause); end
    run_access(0, 1, 2'd2, 0, 32'h3004, 32'hCAFE, 32'h0, 2, 1, 0, 0, 0, 4'h0);
    n_chk++; if ({o_exc, o_cause} !== {1'b1, 4'd7}) begin n_fail++; $display("FAIL store_err_cause: got %b/%0d want 1/7", o_exc, o_cause); end
    run_access(1, 0, 2'd2, 0, 32'h3008, 32'h0, 32'h13579BDF, TO, 0, 0, 0, 0, 4'h0);
    n_chk++; if ({o_exc, o_ld} !== {1'b0, 32'h13579BDF}) begin n_fail++; $display("FAIL ack_beats_timeout: got %b/%h want 0/13579bdf", o_exc, o_ld); end
  endtask

  task automatic test_hold();
    logic [31:0] rd;
    rd = $urandom;
    run_access(1, 0, 2'd2, 0, 32'h4000, 32'h0, rd, 2, 0, 3, 0, 0, 4'h0);
    n_chk++; if (o_hold_bad !== 0) begin n_fail++; $display("FAIL hold_busy_bubble: got %0d bad cycles want 0", o_hold_bad); end
    n_chk++; if (o_ld !== rd) begin n_fail++; $display("FAIL hold_data: got %h want %h", o_ld, rd); end
    n_chk++; if ({o_valid, o_exc} !== 2'b10) begin n_fail++; $display("FAIL hold_valid: got %b%b want 10", o_valid, o_exc); end
  endtask

  task automatic test_invalidate();
    run_access(1, 0, 2'd2, 0, 32'h5000, 32'h0, 32'h1, 3, 1, 0, 1, 0, 4'h0);
    n_chk++; if (o_req_cnt !== 3) begin n_fail++; $display("FAIL inval_req_cycles: got %0d want 3", o_req_cnt); end
    n_chk++; if ({o_valid, o_exc} !== 2'b00) begin n_fail++; $display("FAIL inval_discard: got %b%b want 00", o_valid, o_exc); end
  endtask

  task automatic test_passthrough();
    run_access(1, 0, 2'd2, 0, 32'h6000, 32'h0, 32'h0, 1, 0, 0, 0, 1, 4'hB);
    n_chk++; if ({o_req_cnt == 0, o_exc, o_cause} !== {1'b1, 1'b1, 4'hB}) begin n_fail++; $display("FAIL upstream_exc: got req=%0d exc=%b cause=%h want 0/1/b", o_req_cnt, o_exc, o_cause); end
    run_access(0, 0, 2'd2, 0, 32'h6001, 32'h0, 32'h0, 1, 0, 0, 0, 0, 4'h0);
    n_chk++; if ({o_busy0, o_valid, o_exc} !== 3'b010) begin n_fail++; $display("FAIL nonmem_single_cycle: got busy=%b valid=%b exc=%b want 0 1 0", o_busy0, o_valid, o_exc); end
    n_chk++; if ({o_pc, o_alu, o_wb} !== {e_pc, e_alu, e_wb}) begin n_fail++; $display("FAIL nonmem_passthrough: got %h %h %h want %h %h %h", o_pc, o_alu, o_wb, e_pc, e_alu, e_wb); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      logic ld, st, sg, exc, err, al, mem, strt, inv, ev, ee;
      logic [1:0] sz;
      logic [31:0] a, sd, rd;
      logic [3:0] ec, ecs;
      int lat, sl, ia, kind;
      kind = $urandom_range(0, 9);
      ld = $urandom_range(0, 1); st = !ld;
      if (kind == 0) begin ld = 0; st = 0; end
      exc = (kind == 1); ec = 4'($urandom);
      sz = 2'($urandom_range(0, 2)); sg = $urandom_range(0, 1);
      a = $urandom; sd = $urandom; rd = $urandom;
      if ($urandom_range(0, 4) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      lat = $urandom_range(1, 4); err = ($urandom_range(0, 7) == 0);
      sl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      ia = ($urandom_range(0, 5) == 0) ? $urandom_range(1, lat) : 0;
      run_access(ld, st, sz, sg, a, sd, rd, lat, err, sl, ia, exc, ec);
      al = f_aligned(sz, a); mem = ld | st;
      strt = !exc && mem && al;
      inv = strt && (ia > 0);
      ev = !inv;
      ee = ev && (exc || (mem && !al) || (strt && err));
      ecs = exc ? ec : (mem && !al) ? (ld ? 4'd4 : 4'd6) : (ld ? 4'd5 : 4'd7);
      n_chk++; if (o_req_cnt !== (strt ? lat : 0)) begin n_fail++; $display("FAIL rnd%0d_req_cycles: got %0d want %0d", it, o_req_cnt, strt ? lat : 0); end
      n_chk++; if (o_busy_cnt !== (strt ? lat : 0)) begin n_fail++; $display("FAIL rnd%0d_busy_cycles: got %0d want %0d", it, o_busy_cnt, strt ? lat : 0); end
      n_chk++; if ({o_valid, o_exc} !== {ev, ee}) begin n_fail++; $display("FAIL rnd%0d_valid_exc: got %b%b want %b%b", it, o_valid, o_exc, ev, ee); end
      if (ee) begin
        n_chk++; if (o_cause !== ecs) begin n_fail++; $display("FAIL rnd%0d_cause: got %0d want %0d", it, o_cause, ecs); end
      end
      if (strt) begin
        n_chk++; if ({o_we, o_addr, o_strb, o_stable} !== {st, a & ~32'd3, f_strb(sz, a), 1'b1}) begin n_fail++; $display("FAIL rnd%0d_bus: got we=%b addr=%h strb=%h stable=%b want %b %h %h 1", it, o_we, o_addr, o_strb, o_stable, st, a & ~32'd3, f_strb(sz, a)); end
        n_chk++; if (o_hold_bad !== 0) begin n_fail++; $display("FAIL rnd%0d_hold: got %0d bad cycles want 0", it, o_hold_bad); end
        if (st) begin
          n_chk++; if (o_wdata !== f_wdata(sd, a)) begin n_fail++; $display("FAIL rnd%0d_wdata: got %h want %h", it, o_wdata, f_wdata(sd, a)); end
        end
        if (ld && !err && ev) begin
          n_chk++; if (o_ld !== f_load(rd, a, sz, sg)) begin n_fail++; $display("FAIL rnd%0d_load: got %h want %h", it, o_ld, f_load(rd, a, sz, sg)); end
        end
      end
      if (ev) begin
        n_chk++; if ({o_pc, o_alu, o_wb} !== {e_pc, e_alu, e_wb}) begin n_fail++; $display("FAIL rnd%0d_passthrough: got %h %h %h want %h %h %h", it, o_pc, o_alu, o_wb, e_pc, e_alu, e_wb); end
      end
    end
  endtask

  task automatic test_reset_mid_access();
    valid_in = 1; exception_in = 0; load_in = 1; store_in = 0; size_in = 2'd2; signed_in = 0;
    addr_in = 32'h7000; stall_in = 0; invalidate = 0; bus_ack = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_chk++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_req_before: got %b want 1", bus_req); end
    valid_in = 0; load_in = 0;
    rst_n = 1'b0;
    #1;
    n_chk++; if ({bus_req, busy} !== 2'b00) begin n_fail++; $display("FAIL rstmid_req_drop: got req=%b busy=%b want 0 0", bus_req, busy); end
    @(posedge clk); #1;
    rst_n = 1'b1; bus_ack = 1'b1; bus_err = 1'b1; bus_rdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    n_chk++; if ({bus_req, busy, valid_out, exception_out} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_late_ack: got req=%b busy=%b valid=%b exc=%b want 0000", bus_req, busy, valid_out, exception_out); end
    bus_ack = 1'b0; bus_err = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_misaligned();
    test_faults();
    test_hold();
    test_invalidate();
    test_passthrough();
    test_random();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
